// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: handshake bundle for one pipeline stage register.
// Ports: in_* upstream valid/ready/data, rep_* replay valid/ready/data,
// flush/bubble hazard controls, out_* downstream valid/ready/data,
// occupancy (held entries) and replay_active (head came from replay).
interface pipe_stage_reg_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             rep_valid;
  logic             rep_ready;
  logic [WIDTH-1:0] rep_data;
  logic             flush;
  logic             bubble;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
  logic             replay_active;
  modport master (
    output in_valid, in_data, rep_valid, rep_data, flush, bubble, out_ready,
    input  in_ready, rep_ready, out_valid, out_data, occupancy, replay_active
  );
  modport slave (
    input  in_valid, in_data, rep_valid, rep_data, flush, bubble, out_ready,
    output in_ready, rep_ready, out_valid, out_data, occupancy, replay_active
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with skid, replay, flush and bubble.
// Ports: clk, rst_n (async active-low), bus (slave side of pipe_stage_reg_if).
module pipe_stage_reg #(
  parameter int              WIDTH    = 64,
  parameter bit              SKID     = 1'b1,
  parameter logic [WIDTH-1:0] NOP_WORD = '0
) (
  input logic               clk,
  input logic               rst_n,
  pipe_stage_reg_if.slave   bus
);
  logic             h_v_q, h_r_q, s_v_q, s_r_q;
  logic             h_v_d, h_r_d, s_v_d, s_r_d;
  logic [WIDTH-1:0] h_d_q, s_d_q, h_d_d, s_d_d;
  logic             xfer, space, wr;
  logic [WIDTH-1:0] w_data;
  assign xfer   = h_v_q & bus.out_ready & ~bus.bubble;
  // SKID=1 gates only on the skid slot so in_ready stays off the downstream path
  assign space  = ~bus.flush & (SKID ? ~s_v_q : (~h_v_q | xfer));
  assign bus.rep_ready = space;
  assign bus.in_ready  = space & ~bus.rep_valid;
  assign wr     = (bus.rep_valid & space) | (bus.in_valid & bus.in_ready);
  assign w_data = bus.rep_valid ? bus.rep_data : bus.in_data;
  assign bus.out_valid     = h_v_q & ~bus.bubble;
  assign bus.out_data      = bus.out_valid ? h_d_q : NOP_WORD;
  assign bus.occupancy     = {1'b0, h_v_q} + {1'b0, s_v_q};
  assign bus.replay_active = h_r_q;
  always_comb begin
    h_v_d = h_v_q;
    h_r_d = h_r_q;
    h_d_d = h_d_q;
    s_v_d = s_v_q;
    s_r_d = s_r_q;
    s_d_d = s_d_q;
    if (bus.flush) begin
      h_v_d = 1'b0;
      h_r_d = 1'b0;
      s_v_d = 1'b0;
      s_r_d = 1'b0;
    end else if (xfer | ~h_v_q) begin
      // head slot frees up: promote skid first (oldest), else take the new write
      h_v_d = s_v_q | wr;
      h_r_d = s_v_q ? s_r_q : (wr & bus.rep_valid);
      h_d_d = s_v_q ? s_d_q : w_data;
      s_v_d = 1'b0;
      s_r_d = 1'b0;
    end else if (wr) begin
      s_v_d = SKID;
      s_r_d = SKID & bus.rep_valid;
      s_d_d = w_data;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_v_q <= 1'b0;
      h_r_q <= 1'b0;
      h_d_q <= NOP_WORD;
      s_v_q <= 1'b0;
      s_r_q <= 1'b0;
      s_d_q <= NOP_WORD;
    end else begin
      h_v_q <= h_v_d;
      h_r_q <= h_r_d;
      h_d_q <= h_d_d;
      s_v_q <= s_v_d;
      s_r_q <= s_r_d;
      s_d_q <= s_d_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random checks of SKID=1 and SKID=0 stages against a FIFO model.
module tb_pipe_stage_reg;
  localparam logic [63:0] NOP = 64'h0000_0000_0000_0F0F;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 0, rep_valid = 0, flush = 0, bubble = 0, out_ready = 0;
  logic [63:0] in_data = '0, rep_data = '0;
  int checks = 0, failures = 0;
  logic [63:0] md[2][2];
  bit mr[2][2];
  int mn[2];
  always #5 clk = ~clk;
  pipe_stage_reg_if #(.WIDTH(64)) i1 ();
  pipe_stage_reg_if #(.WIDTH(64)) i0 ();
  assign i1.in_valid = in_valid;   assign i0.in_valid = in_valid;
  assign i1.in_data = in_data;     assign i0.in_data = in_data;
  assign i1.rep_valid = rep_valid; assign i0.rep_valid = rep_valid;
  assign i1.rep_data = rep_data;   assign i0.rep_data = rep_data;
  assign i1.flush = flush;         assign i0.flush = flush;
  assign i1.bubble = bubble;       assign i0.bubble = bubble;
  assign i1.out_ready = out_ready; assign i0.out_ready = out_ready;
  pipe_stage_reg #(.WIDTH(64), .SKID(1'b1), .NOP_WORD(NOP)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
  pipe_stage_reg #(.WIDTH(64), .SKID(1'b0), .NOP_WORD(NOP)) u0 (.clk(clk), .rst_n(rst_n), .bus(i0.slave));
  task automatic chk(input string tag, input logic [63:0] a, input logic [63:0] e);
    checks++;
    assert (a === e) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, a, e);
    end
  endtask
  // model: stage k is a FIFO of capacity 2 (k=1) or 1 (k=0)
  task automatic cmp(input int k, input logic ir_a, input logic rr_a, input logic ov_a,
                     input logic [63:0] od_a, input logic [1:0] oc_a, input logic ra_a);
    int n;
    logic ov_e, xf, sp, ir_e, acc;
    n = mn[k];
    ov_e = (n > 0) && !bubble;
    xf = ov_e && out_ready;
    sp = !flush && ((k == 1) ? (n < 2) : (n == 0 || xf));
    ir_e = sp && !rep_valid;
    acc = (rep_valid && sp) || (in_valid && ir_e);
    chk($sformatf("k%0d_in_ready", k), 64'(ir_a), 64'(ir_e));
    chk($sformatf("k%0d_rep_ready", k), 64'(rr_a), 64'(sp));
    chk($sformatf("k%0d_out_valid", k), 64'(ov_a), 64'(ov_e));
    chk($sformatf("k%0d_out_data", k), od_a, ov_e ? md[k][0] : NOP);
    chk($sformatf("k%0d_occupancy", k), 64'(oc_a), 64'(n));
    chk($sformatf("k%0d_replay_active", k), 64'(ra_a), 64'((n > 0) ? mr[k][0] : 1'b0));
    if (flush) n = 0;
    else begin
      if (xf) begin
        md[k][0] = md[k][1];
        mr[k][0] = mr[k][1];
        n--;
      end
      if (acc) begin
        md[k][n] = rep_valid ? rep_data : in_data;
        mr[k][n] = rep_valid;
        n++;
      end
    end
    mn[k] = n;
  endtask
  task automatic step(input logic iv, input logic [63:0] id, input logic rv, input logic [63:0] rd,
                      input logic fl, input logic bb, input logic ordy);
    in_valid = iv; in_data = id; rep_valid = rv; rep_data = rd;
    flush = fl; bubble = bb; out_ready = ordy;
    #1;
    cmp(1, i1.in_ready, i1.rep_ready, i1.out_valid, i1.out_data, i1.occupancy, i1.replay_active);
    cmp(0, i0.in_ready, i0.rep_ready, i0.out_valid, i0.out_data, i0.occupancy, i0.replay_active);
    @(negedge clk);
  endtask
  initial begin
    mn[0] = 0; mn[1] = 0;
    #3;
    chk("rst_occ1", 64'(i1.occupancy), 64'd0);
    chk("rst_ov1", 64'(i1.out_valid), 64'd0);
    chk("rst_od1", i1.out_data, NOP);
    chk("rst_ra1", 64'(i1.replay_active), 64'd0);
    chk("rst_ov0", 64'(i0.out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // streaming 1..5
    for (int i = 1; i <= 5; i++) step(1, 64'(i), 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    // backpressure
    step(1, 64'hA, 0, 0, 0, 0, 0);
    step(1, 64'hB, 0, 0, 0, 0, 0);
    #1 chk("bp_occ", 64'(i1.occupancy), 64'd2);
    chk("bp_in_ready", 64'(i1.in_ready), 64'd0);
    chk("bp_head", i1.out_data, 64'hA);
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    // replay priority over upstream
    step(1, 64'h10, 1, 64'h99, 0, 0, 1);
    #1 chk("rep_head", i1.out_data, 64'h99);
    chk("rep_flag", 64'(i1.replay_active), 64'd1);
    @(negedge clk);
    step(1, 64'h10, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    // flush with full skid and a competing input
    step(1, 64'h3, 0, 0, 0, 0, 0);
    step(1, 64'h4, 0, 0, 0, 0, 0);
    step(1, 64'h7, 0, 0, 1, 0, 0);
    #1 chk("fl_occ", 64'(i1.occupancy), 64'd0);
    chk("fl_od", i1.out_data, NOP);
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 0);
    // bubble holds the head
    step(1, 64'h5, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    // async reset mid-operation
    step(1, 64'h3, 0, 0, 0, 0, 0);
    step(1, 64'h4, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk("ar_ov1", 64'(i1.out_valid), 64'd0);
    chk("ar_occ1", 64'(i1.occupancy), 64'd0);
    chk("ar_occ0", 64'(i0.occupancy), 64'd0);
    mn[0] = 0; mn[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1);
    // SKID=0 in_ready tracks out_ready with a held head
    step(1, 64'h21, 0, 0, 0, 0, 0);
    step(1, 64'h22, 0, 0, 0, 0, 0);
    step(1, 64'h23, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 1'($urandom_range(0, 7) == 0),
           {$urandom, $urandom}, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 2) != 0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
